// File: rtl/jtkcpu_stkseq_pkg.sv
// jtkcpu_stkseq_pkg: shared constants and types for the stack-transfer sequencer
// Holds CC flag indices, register bit positions in the push/pull mask,
// interrupt-frame mask defaults and the sequencer state type.
package jtkcpu_stkseq_pkg;

    localparam int CC_E = 7;

    localparam int REG_CC = 0;
    localparam int REG_A  = 1;
    localparam int REG_B  = 2;
    localparam int REG_DP = 3;
    localparam int REG_X  = 4;
    localparam int REG_Y  = 5;
    localparam int REG_U  = 6;
    localparam int REG_PC = 7;

    localparam int         NREG_D    = 8;
    localparam logic [7:0] WIDE_D    = 8'hF0;
    localparam logic [7:0] FULLMSK_D = 8'hFF;
    localparam logic [7:0] FASTMSK_D = 8'h81;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/jtkcpu_prienc.sv
// jtkcpu_prienc: parametrised priority encoder with selectable search direction
// Ports: din (N-bit request mask), msb_first (1 = highest set bit wins,
// 0 = lowest set bit wins), dout (one-hot winner, 0 when din is 0),
// any (din has at least one bit set).
module jtkcpu_prienc #(
    parameter int N = 8
) (
    input  logic [N-1:0] din,
    input  logic         msb_first,
    output logic [N-1:0] dout,
    output logic         any
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < N; i++)
            if (din[i] && (msb_first || !(|dout))) begin
                dout    = '0;
                dout[i] = 1'b1;
            end
    end

    assign any = |din;

endmodule

// File: rtl/jtkcpu_stkseq.sv
// jtkcpu_stkseq: stack-transfer sequencer emitting one request per stack byte
// Ports: clk, rst (async, active high), cen (clock enable);
// psh_go/pul_go start a push/pull, int_en/cc_e pick the interrupt frame mask,
// op_us selects the U stack, postdata is the instruction register mask,
// ack accepts the current byte. Outputs: req, reg_sel (one-hot register),
// byte_hi, dec_sp/inc_sp, us_sel, idle, done (one-cen pulse), nbytes.
module jtkcpu_stkseq
    import jtkcpu_stkseq_pkg::*;
#(
    parameter int              NREG    = NREG_D,
    parameter logic [NREG-1:0] WIDE    = NREG'(WIDE_D),
    parameter logic [NREG-1:0] FULLMSK = NREG'(FULLMSK_D),
    parameter logic [NREG-1:0] FASTMSK = NREG'(FASTMSK_D),
    localparam int             NBW     = $clog2(2*NREG+1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            psh_go,
    input  logic            pul_go,
    input  logic            int_en,
    input  logic            cc_e,
    input  logic            op_us,
    input  logic [NREG-1:0] postdata,
    input  logic            ack,
    output logic            req,
    output logic [NREG-1:0] reg_sel,
    output logic            byte_hi,
    output logic            dec_sp,
    output logic            inc_sp,
    output logic            us_sel,
    output logic            idle,
    output logic            done,
    output logic [NBW-1:0]  nbytes
);

    state_t          st;
    logic [NREG-1:0] mask, mask_nx, smask, sel_nx;
    logic            dir, dir_nx, start, adv, first, any_nx, hi_nx;

    assign smask = int_en ? (cc_e ? FULLMSK : FASTMSK) : postdata;
    assign start = st == ST_IDLE && (psh_go || pul_go);
    assign adv   = st == ST_XFER && ack && req;
    // A wide register's first byte is low for push (dir=1) and high for pull,
    // so it is the first byte exactly when byte_hi differs from dir.
    assign first = |(reg_sel & WIDE) && (byte_hi != dir);

    // Encode the register for the next cycle so reg_sel can be registered.
    always_comb begin
        mask_nx = start ? smask : (adv && !first) ? mask & ~reg_sel : mask;
        dir_nx  = start ? psh_go : dir;
    end

    jtkcpu_prienc #(.N(NREG)) u_prienc (
        .din       (mask_nx),
        .msb_first (dir_nx),
        .dout      (sel_nx),
        .any       (any_nx)
    );

    assign hi_nx  = |(sel_nx & WIDE) && !dir_nx;
    assign dec_sp = req && dir;
    assign inc_sp = req && !dir;
    assign idle   = st == ST_IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= ST_IDLE;
            mask    <= '0;
            dir     <= 1'b0;
            us_sel  <= 1'b0;
            req     <= 1'b0;
            reg_sel <= '0;
            byte_hi <= 1'b0;
            done    <= 1'b0;
            nbytes  <= '0;
        end else if (cen) begin
            mask <= mask_nx;
            dir  <= dir_nx;
            case (st)
                ST_IDLE: if (start) begin
                    us_sel  <= op_us;
                    nbytes  <= '0;
                    req     <= any_nx;
                    reg_sel <= sel_nx;
                    byte_hi <= hi_nx;
                    done    <= !any_nx;
                    st      <= any_nx ? ST_XFER : ST_DONE;
                end
                ST_XFER: if (adv) begin
                    nbytes <= nbytes + NBW'(1);
                    if (first) byte_hi <= ~byte_hi;
                    else begin
                        req     <= any_nx;
                        reg_sel <= sel_nx;
                        byte_hi <= hi_nx;
                        done    <= !any_nx;
                        st      <= any_nx ? ST_XFER : ST_DONE;
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    st   <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule
